ov7670_capture: RTL and testbench



---
 rtl/ov7670_capture_pkg.sv | 20 ++
 rtl/ov7670_capture_geometry_checker.sv | 66 ++++++
 rtl/ov7670_capture.sv | 151 +++++++++++++++
 tb/tb_ov7670_capture.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 capture stage: queue word format,
// frame-start marker, FSM state encoding and a saturating counter helper.
package ov7670_capture_pkg;

  localparam int QUEUE_WIDTH = 17;
  localparam logic [QUEUE_WIDTH-1:0] FRAME_START_MARKER = 17'h10000;

  typedef enum logic [2:0] {
    WAIT_CALIBRATION,
    WAIT_VBLANK,
    WAIT_FRAME_START,
    ROW_CAPTURE,
    DROP_FRAME
  } capture_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/ov7670_capture_geometry_checker.sv
// Line/frame geometry checker for the OV7670 capture stage. Counts byte
// pairs per line and lines per frame (both saturating) and raises a sticky
// error when a line or a frame does not match the configured size.
// Only instantiated when CAPTURE_GEOMETRY_CHECK_EN is defined.
module capture_geometry_checker
  import ov7670_capture_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic clk,
  input  logic reset_p,
  input  logic frame_start,
  input  logic frame_end,
  input  logic in_row,
  input  logic href_r,
  input  logic pixel_half,
  output logic geometry_error
);

  localparam int PIX_W  = $clog2(FRAME_WIDTH + 1);
  localparam int LINE_W = $clog2(FRAME_HEIGHT + 1);

  logic [PIX_W-1:0]  pix_count;
  logic [LINE_W-1:0] line_count;
  logic              href_d;
  logic              line_end;
  logic              pair_done;

  assign line_end  = in_row & href_d & ~href_r;
  assign pair_done = in_row & href_r & pixel_half;

  // Saturating pixel-pair and line counters, cleared at every frame start
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      href_d     <= 1'b0;
      pix_count  <= '0;
      line_count <= '0;
    end else begin
      href_d <= href_r;
      if (frame_start) begin
        pix_count  <= '0;
        line_count <= '0;
      end else if (line_end) begin
        pix_count <= '0;
        if (line_count != '1) line_count <= line_count + 1'b1;
      end else if (pair_done && pix_count != '1) begin
        pix_count <= pix_count + 1'b1;
      end
    end
  end

  // Sticky mismatch flag: wrong pair count or a dangling byte at line end,
  // wrong line count at frame end
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      geometry_error <= 1'b0;
    end else begin
      if (line_end && (pix_count != PIX_W'(FRAME_WIDTH) || pixel_half))
        geometry_error <= 1'b1;
      if (frame_end && line_count != LINE_W'(FRAME_HEIGHT))
        geometry_error <= 1'b1;
    end
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture stage: packs camera byte pairs into RGB565 words and writes
// a frame-start marker plus one 17-bit word per pixel into the camera FIFO.
// Detects FIFO overflow, drops the rest of an overflowed frame and reports
// frame/geometry status. Optional geometry checking is enabled by defining
// CAPTURE_GEOMETRY_CHECK_EN.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                   clk,
  input  logic                   reset_p,
  input  logic                   init_done,
  input  logic                   cam_vsync,
  input  logic                   href,
  input  logic [7:0]             p_data,
  input  logic                   queue_full,
  output logic [QUEUE_WIDTH-1:0] queue_data,
  output logic                   queue_wr_en,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   geometry_error,
  output logic [7:0]             frames_dropped
);

  if (FRAME_WIDTH < 1 || FRAME_HEIGHT < 1) begin : g_bad_geometry
    $error("ov7670_capture: frame dimensions must be positive");
  end

  capture_state_t state;
  logic           vsync_r;
  logic           vsync_d;
  logic           href_r;
  logic [7:0]     data_r;
  logic [7:0]     pix_hi;
  logic           pixel_half;
  logic           vsync_fall;
  logic           vsync_rise;

  assign vsync_fall = vsync_d & ~vsync_r;
  assign vsync_rise = ~vsync_d & vsync_r;

  // Register the camera pins once; every decision uses these copies
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      vsync_r <= 1'b0;
      vsync_d <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= 8'h00;
    end else begin
      vsync_r <= cam_vsync;
      vsync_d <= vsync_r;
      href_r  <= href;
      data_r  <= p_data;
    end
  end

  // Capture FSM with registered FIFO write port and status outputs
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state          <= WAIT_CALIBRATION;
      queue_data     <= '0;
      queue_wr_en    <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      frames_dropped <= 8'h00;
      pix_hi         <= 8'h00;
      pixel_half     <= 1'b0;
    end else begin
      queue_wr_en <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        WAIT_CALIBRATION: begin
          if (init_done) state <= WAIT_VBLANK;
        end
        WAIT_VBLANK: begin
          if (vsync_r) state <= WAIT_FRAME_START;
        end
        WAIT_FRAME_START: begin
          pixel_half <= 1'b0;
          if (vsync_fall) begin
            if (queue_full) begin
              overflow       <= 1'b1;
              frames_dropped <= sat_inc8(frames_dropped);
              state          <= DROP_FRAME;
            end else begin
              queue_data  <= FRAME_START_MARKER;
              queue_wr_en <= 1'b1;
              state       <= ROW_CAPTURE;
            end
          end
        end
        ROW_CAPTURE: begin
          if (vsync_rise) begin
            frame_done <= 1'b1;
            pixel_half <= 1'b0;
            state      <= WAIT_FRAME_START;
          end else if (!href_r) begin
            pixel_half <= 1'b0;
          end else if (!pixel_half) begin
            pix_hi     <= data_r;
            pixel_half <= 1'b1;
          end else begin
            pixel_half <= 1'b0;
            if (queue_full) begin
              overflow       <= 1'b1;
              frames_dropped <= sat_inc8(frames_dropped);
              state          <= DROP_FRAME;
            end else begin
              queue_data  <= {1'b0, pix_hi, data_r};
              queue_wr_en <= 1'b1;
            end
          end
        end
        DROP_FRAME: begin
          pixel_half <= 1'b0;
          if (vsync_rise) state <= WAIT_FRAME_START;
        end
        default: state <= WAIT_CALIBRATION;
      endcase
    end
  end

`ifdef CAPTURE_GEOMETRY_CHECK_EN
  logic frame_start;
  logic frame_end;
  logic in_row;

  assign frame_start = (state == WAIT_FRAME_START) && vsync_fall && !queue_full;
  assign frame_end   = (state == ROW_CAPTURE) && vsync_rise;
  assign in_row      = (state == ROW_CAPTURE);

  capture_geometry_checker #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_geometry (
    .clk           (clk),
    .reset_p       (reset_p),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .in_row        (in_row),
    .href_r        (href_r),
    .pixel_half    (pixel_half),
    .geometry_error(geometry_error)
  );
`else
  assign geometry_error = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Testbench for ov7670_capture: frame-level vector table plus hand-written
// sequences for calibration gating and mid-line reset.
module tb_ov7670_capture;
  import ov7670_capture_pkg::*;

  localparam int FW = 4;
  localparam int FH = 2;
`ifdef CAPTURE_GEOMETRY_CHECK_EN
  localparam bit GEOM_ON = 1'b1;
`else
  localparam bit GEOM_ON = 1'b0;
`endif

  typedef struct {
    int pix0;
    int pix1;
    bit odd0;
    int full_idx;
    int exp_done;
    bit exp_geom;
    int exp_dropped;
    bit exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        init_done;
  logic        cam_vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        queue_full;
  logic [16:0] queue_data;
  logic        queue_wr_en;
  logic        frame_done;
  logic        overflow;
  logic        geometry_error;
  logic [7:0]  frames_dropped;

  int          checks = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          full_hold = 0;
  logic [7:0]  byte_seed;
  logic [16:0] wq[$];
  logic [16:0] exp_q[$];
  vec_t        vecs[6];

  always #5 clk = ~clk;

  ov7670_capture #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .init_done     (init_done),
    .cam_vsync     (cam_vsync),
    .href          (href),
    .p_data        (p_data),
    .queue_full    (queue_full),
    .queue_data    (queue_data),
    .queue_wr_en   (queue_wr_en),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .geometry_error(geometry_error),
    .frames_dropped(frames_dropped)
  );

  // Collect FIFO writes and frame_done pulses away from the active edge
  always @(negedge clk) begin
    if (queue_wr_en) wq.push_back(queue_data);
    if (frame_done) done_cnt++;
  end

  // Hard stop in case the run never reaches its summary
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic [7:0] d);
    href   = h;
    p_data = d;
    @(posedge clk);
    #2;
    if (full_hold > 0) begin
      full_hold--;
      if (full_hold == 0) queue_full = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " queue_data"}, queue_data, 32'h0);
    check({tag, " queue_wr_en"}, queue_wr_en, 32'h0);
    check({tag, " frame_done"}, frame_done, 32'h0);
    check({tag, " overflow"}, overflow, 32'h0);
    check({tag, " geometry_error"}, geometry_error, 32'h0);
    check({tag, " frames_dropped"}, frames_dropped, 32'h0);
  endtask

  // Drive one frame (vsync low, FH lines, vsync high) and build expected words
  task automatic gen_frame(input vec_t v);
    int          pidx;
    int          n;
    logic [7:0]  b1;
    logic [7:0]  b2;
    exp_q.delete();
    exp_q.push_back(FRAME_START_MARKER);
    pidx = 0;
    cam_vsync = 1'b0;
    repeat (3) drive(1'b0, 8'h00);
    for (int l = 0; l < FH; l++) begin
      n = (l == 0) ? v.pix0 : v.pix1;
      for (int p = 0; p < n; p++) begin
        b1 = byte_seed;
        byte_seed = byte_seed + 8'h11;
        b2 = byte_seed;
        byte_seed = byte_seed + 8'h11;
        drive(1'b1, b1);
        if (pidx == v.full_idx) begin
          queue_full = 1'b1;
          full_hold  = 2;
        end
        drive(1'b1, b2);
        if (v.full_idx < 0 || pidx < v.full_idx) exp_q.push_back({1'b0, b1, b2});
        pidx++;
      end
      if (l == 0 && v.odd0) begin
        drive(1'b1, byte_seed);
        byte_seed = byte_seed + 8'h11;
      end
      repeat (3) drive(1'b0, 8'h00);
    end
    cam_vsync = 1'b1;
    repeat (4) drive(1'b0, 8'h00);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    logic [16:0] got;
    wq.delete();
    done_cnt = 0;
    gen_frame(v);
    check($sformatf("v%0d word_count", idx), wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wq.size()) ? wq[i] : 17'h1FFFF;
      check($sformatf("v%0d word%0d", idx, i), got, exp_q[i]);
    end
    check($sformatf("v%0d frame_done", idx), done_cnt, v.exp_done);
    check($sformatf("v%0d overflow", idx), overflow, v.exp_ovf);
    check($sformatf("v%0d frames_dropped", idx), frames_dropped, v.exp_dropped);
    check($sformatf("v%0d geometry_error", idx), geometry_error, v.exp_geom & GEOM_ON);
  endtask

  initial begin
    vecs[0] = '{pix0: 4, pix1: 4, odd0: 0, full_idx: -1, exp_done: 1, exp_geom: 0, exp_dropped: 0, exp_ovf: 0};
    vecs[1] = '{pix0: 4, pix1: 4, odd0: 0, full_idx: -1, exp_done: 1, exp_geom: 0, exp_dropped: 0, exp_ovf: 0};
    vecs[2] = '{pix0: 4, pix1: 4, odd0: 0, full_idx: 2,  exp_done: 0, exp_geom: 0, exp_dropped: 1, exp_ovf: 1};
    vecs[3] = '{pix0: 4, pix1: 4, odd0: 0, full_idx: -1, exp_done: 1, exp_geom: 0, exp_dropped: 1, exp_ovf: 1};
    vecs[4] = '{pix0: 3, pix1: 4, odd0: 0, full_idx: -1, exp_done: 1, exp_geom: 1, exp_dropped: 1, exp_ovf: 1};
    vecs[5] = '{pix0: 4, pix1: 4, odd0: 1, full_idx: -1, exp_done: 1, exp_geom: 1, exp_dropped: 0, exp_ovf: 0};

    reset_p    = 1'b1;
    init_done  = 1'b0;
    cam_vsync  = 1'b1;
    href       = 1'b0;
    p_data     = 8'h00;
    queue_full = 1'b0;
    byte_seed  = 8'hA1;

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    reset_p = 1'b0;
    repeat (2) drive(1'b0, 8'h00);

    // Frames before calibration completes must produce no writes
    wq.delete();
    gen_frame(vecs[0]);
    gen_frame(vecs[0]);
    check("no_write_before_init", wq.size(), 0);

    // Calibration completes mid-frame: that frame must not be captured
    cam_vsync = 1'b0;
    repeat (3) drive(1'b0, 8'h00);
    for (int p = 0; p < FW; p++) begin
      drive(1'b1, 8'h12);
      drive(1'b1, 8'h34);
      if (p == 1) init_done = 1'b1;
    end
    repeat (3) drive(1'b0, 8'h00);
    cam_vsync = 1'b1;
    repeat (4) drive(1'b0, 8'h00);
    check("no_write_partial_frame", wq.size(), 0);

    byte_seed = 8'hA1;
    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], i);

    // Reset in the middle of a line
    cam_vsync = 1'b0;
    repeat (3) drive(1'b0, 8'h00);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h66);
    drive(1'b1, 8'h77);
    #1;
    reset_p = 1'b1;
    #1;
    check_reset_outputs("midline_reset");
    @(posedge clk);
    #2;
    reset_p = 1'b0;
    wq.delete();
    drive(1'b1, 8'h88);
    repeat (3) drive(1'b0, 8'h00);
    cam_vsync = 1'b1;
    repeat (4) drive(1'b0, 8'h00);
    check("no_write_after_reset", wq.size(), 0);

    byte_seed = 8'h10;
    apply_stimulus(vecs[5], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
